multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences a shared-memory, single-ALU MIPS datapath over several cycles.
//  It issues the PC, IR, register-file, ALU, memory and mux controls per state.
//  It stalls on memory wait states and traps illegal opcodes.
//  It sits beside the datapath top and replaces the single-cycle combinational control.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter
// PORTS
//  clock          in   1   rising-edge clock
//  Reset          in   1   synchronous, active-low reset (0 = reset)
//  opcode         in   6   IR[31:26]; stable from DECODE onward
//  funct          in   6   IR[5:0]
//  zero_flag      in   1   ALU zero output
//  mem_ready      in   1   memory completes the current access this cycle
//  pc_write       out  1   load PC (already gated by branch condition)
//  iord           out  1   memory address: 0 = PC, 1 = ALUOut
//  mem_read       out  1   memory read request
//  mem_write      out  1   memory write request
//  ir_write       out  1   load IR from memory data
//  reg_write      out  1   register-file write enable
//  reg_dst        out  2   write address: 00 = rt, 01 = rd, 10 = 5'd31
//  mem_to_reg     out  2   write data: 00 = ALUOut, 01 = MDR, 10 = PC
//  alu_src_a      out  1   ALU A input: 0 = PC, 1 = regA
//  alu_src_b      out  2   ALU B input: 00 = regB, 01 = 4, 10 = signext, 11 = signext<<2
//  ALUOp          out  3   000 = ADD, 001 = SUB, 010 = FUNCT (decoded by ula_ctrl)
//  pc_source      out  2   PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = regA
//  illegal        out  1   high while in TRAP
//  state          out  4   current state (debug)
//  instr_retired  out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - Reset==0 at a clock edge: state <= FETCH, instr_retired <= 0.
//  - While Reset==0, every control output is forced to 0 (combinationally gated) and illegal=0.
//  - States and transitions:
//    FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD.
//      ir_write and pc_write (pc_source=00) are asserted only when mem_ready=1; then go to DECODE.
//      If mem_ready=0, hold in FETCH with no writes.
//    DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//      000000 with funct 001000 -> JR; other 000000 -> REXEC;
//      100011/101011 -> MEMADR; 000100/000101 -> BRANCH; 001000 -> IEXEC;
//      000010 -> JUMP; 000011 -> JAL; any other opcode -> TRAP.
//    MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEMRD; sw -> MEMWR.
//    MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
//    MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01.
//    MEMWR: mem_write=1, iord=1. Hold until mem_ready=1. mem_write stays high for the whole wait.
//    REXEC: alu_src_a=1, alu_src_b=00, FUNCT. Next: RWB.
//    RWB: reg_write=1, reg_dst=01, mem_to_reg=00.
//    IEXEC: alu_src_a=1, alu_src_b=10, ADD. Next: IWB.
//    IWB: reg_write=1, reg_dst=00, mem_to_reg=00.
//    BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01.
//      pc_write = zero_flag XOR (opcode==000101).
//    JUMP: pc_write=1, pc_source=10.
//    JAL: JUMP controls plus reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4).
//    JR: pc_write=1, pc_source=11.
//    TRAP: illegal=1, all other controls 0. Absorbing until Reset==0.
//  - Completion states MEMWB, MEMWR(ready), RWB, IWB, BRANCH, JUMP, JAL and JR return to FETCH.
//    On that transition instr_retired increments by 1, wrapping modulo 2^CNT_W.
//  - Latency, with mem_ready=1 throughout:
//    R/addi/sw = 4 cycles; lw = 5; beq/bne/j/jal/jr = 3.
//    Each mem_ready=0 cycle adds exactly one cycle.
//  - Any control not listed for a state is 0.
//  - Reset asserted mid-instruction aborts it: no counter increment, no pending write.
// STRUCTURE
//  - Package mips_ctrl_pkg holds the state enum (4-bit localparams), opcode/funct constants,
//    and the ALUOp, pc_source, reg_dst and mem_to_reg encodings.
//  - One sub-module, multicycle_out_dec, is purely combinational:
//    state, opcode, zero_flag, mem_ready -> control outputs.
//  - The top holds the state register, next-state logic and counter.
// TESTING
//  - Reset held 2 cycles, then released with mem_ready=1, opcode=000000, funct=100000:
//    states FETCH, DECODE, REXEC, RWB, FETCH; reg_write=1 only in RWB with reg_dst=01; instr_retired=1.
//  - lw (100011) with mem_ready low for 2 cycles in MEMRD: 7 cycles total;
//    mem_read high for all 3 MEMRD cycles; MEMWB has mem_to_reg=01.
//  - beq with zero_flag=1 -> pc_write=1 in BRANCH.
//    bne with zero_flag=1 -> pc_write=0. Both return to FETCH.
//  - jal (000011): JAL state asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
//  - opcode 111111 -> TRAP after DECODE; illegal stays 1 for 10 cycles.
//    Reset=0 returns to FETCH with instr_retired=0.
//  - Reset=0 during MEMWR wait: next cycle in FETCH, mem_write=0, counter unchanged.
//    Counter preloaded via force to all-ones wraps to 0 on the next retire.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct constants, datapath mux encodings and the control bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Every datapath control driven by the FSM, in one bundle.
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_out_dec.sv
// Moore output decoder: maps the current state (plus the few inputs that
// qualify writes) onto the datapath control bundle. Purely combinational.
module multicycle_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_flag_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  ctrl_t c;

  // Per-state control table; anything not set for a state stays 0.
  always_comb begin
    c = '0;
    case (state_i)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
        // IR and PC+4 only commit on the cycle the instruction word arrives.
        if (mem_ready_i) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RD_RT;
        c.mem_to_reg = WB_MDR;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_REXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RD_RD;
        c.mem_to_reg = WB_ALUOUT;
      end
      S_IWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RD_RT;
        c.mem_to_reg = WB_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCS_ALUOUT;
        // bne inverts the sense of the equality test.
        c.pc_write  = zero_flag_i ^ (opcode_i == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCS_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = RD_RA;
        c.mem_to_reg = WB_PC;
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_REGA;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter. Outputs are decoded from the state by
// multicycle_out_dec and forced low while Reset is asserted.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       ALUOp,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_retired_q, instr_retired_d;
  logic             retire;
  ctrl_t            ctrl_raw, ctrl_g;

  // Next state; retire flags every transition that completes an instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = (funct == FN_JR) ? S_JR : S_REXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_IEXEC;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retired-instruction count wraps naturally at 2^CNT_W.
  always_comb begin
    instr_retired_d = instr_retired_q;
    if (retire) instr_retired_d = instr_retired_q + CNT_W'(1);
  end

  // State and counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q         <= S_FETCH;
      instr_retired_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  multicycle_out_dec u_out_dec (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .zero_flag_i (zero_flag),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // Hold every control low during reset so no write escapes.
  always_comb begin
    ctrl_g = '0;
    if (Reset) ctrl_g = ctrl_raw;
  end

  assign pc_write      = ctrl_g.pc_write;
  assign iord          = ctrl_g.iord;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign reg_write     = ctrl_g.reg_write;
  assign reg_dst       = ctrl_g.reg_dst;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign ALUOp         = ctrl_g.alu_op;
  assign pc_source     = ctrl_g.pc_source;
  assign illegal       = ctrl_g.illegal;
  assign state         = state_q;
  assign instr_retired = instr_retired_q;

endmodule
